// File: rtl/conv_frame_streamer_if.sv
// conv_frame_streamer_if
//   Bundles the BRAM read port and the pixel/arm/status link to the conv block
//   so they travel as one port on conv_frame_streamer.
//   master : the frame streamer (drives BRAM address/enable, pixels, arm pulse)
//   slave  : the BRAM + conv block side (returns read data and running flag)
// Signals
//   mem_en_o       BRAM read enable
//   mem_addr_o     BRAM read address
//   mem_data_i     BRAM read data, one cycle after mem_en_o
//   conv_ena_o     one-cycle arm pulse to the conv block
//   pix_o          pixel to the conv block
//   pix_valid_o    pix_o qualifier
//   conv_running_i conv block busy flag
interface conv_frame_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  conv_ena_o;
  logic [DATA_WIDTH-1:0] pix_o;
  logic                  pix_valid_o;
  logic                  conv_running_i;

  modport master (
    output mem_en_o, mem_addr_o, conv_ena_o, pix_o, pix_valid_o,
    input  mem_data_i, conv_running_i
  );

  modport slave (
    input  mem_en_o, mem_addr_o, conv_ena_o, pix_o, pix_valid_o,
    output mem_data_i, conv_running_i
  );
endinterface

// File: rtl/conv_frame_streamer.sv
// conv_frame_streamer
//   Source side of the convolutor pixel stream. On start it arms the conv block
//   with a one-cycle pulse, reads an N x N frame row-major from a synchronous
//   BRAM, forwards each pixel with a valid qualifier, waits for the conv block
//   to go idle and then pulses done_o.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start_i       start one frame (only honoured in IDLE)
//   base_addr_i   BRAM address of pixel 0, latched on an accepted start
//   stall_i       1 = issue no new BRAM read this cycle
//   busy_o        1 whenever the FSM is not IDLE
//   done_o        one-cycle pulse when the frame has been fully processed
//   bus           BRAM read port + conv block link (master side)
module conv_frame_streamer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  done_o,
  conv_frame_streamer_if.master bus
);

  localparam int PIX   = N * N;
  localparam int IDX_W = $clog2(PIX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_WAITC,
    S_DONE
  } state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic                  rd_pend_reg;     // a read was issued last cycle
  logic [DATA_WIDTH-1:0] pix_reg;
  logic                  pix_valid_reg;
  logic                  conv_ena_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  waitc_armed_reg; // first WAITC cycle has passed

  // The read issue must react to stall_i in the same cycle, so enable and
  // address are decoded from registered state rather than registered again.
  logic rd_issue;
  assign rd_issue = (state_reg == S_STREAM) && !stall_i;

  assign bus.mem_en_o    = rd_issue;
  assign bus.mem_addr_o  = rd_issue ? (base_reg + ADDR_WIDTH'(idx_reg)) : '0;
  assign bus.conv_ena_o  = conv_ena_reg;
  assign bus.pix_o       = pix_reg;
  assign bus.pix_valid_o = pix_valid_reg;
  assign busy_o          = busy_reg;
  assign done_o          = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      base_reg        <= '0;
      rd_pend_reg     <= 1'b0;
      pix_reg         <= '0;
      pix_valid_reg   <= 1'b0;
      conv_ena_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      waitc_armed_reg <= 1'b0;
    end else begin
      conv_ena_reg <= 1'b0;
      done_reg     <= 1'b0;

      // Two-stage read pipe: issue -> BRAM data -> registered pixel.
      // In-flight reads always complete regardless of FSM state.
      rd_pend_reg   <= rd_issue;
      pix_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) begin
        pix_reg <= bus.mem_data_i;
      end

      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            base_reg     <= base_addr_i;
            idx_reg      <= '0;
            conv_ena_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= S_ARM;
          end
        end
        S_ARM: begin
          state_reg <= S_STREAM;
        end
        S_STREAM: begin
          if (rd_issue) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // No reads are issued here, so the pipe is empty once the last
          // pixel is on the output and nothing is still pending behind it.
          if (pix_valid_reg && !rd_pend_reg) begin
            waitc_armed_reg <= 1'b0;
            state_reg       <= S_WAITC;
          end
        end
        S_WAITC: begin
          // Skip the entry cycle so the conv block's registered running
          // flag reflects the final pixel before we trust it.
          waitc_armed_reg <= 1'b1;
          if (waitc_armed_reg && !bus.conv_running_i) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_streamer.sv
// tb_conv_frame_streamer
//   Drives frames into conv_frame_streamer with a behavioural BRAM and conv
//   block model. Each accepted start pushes the expected address sequence and
//   pixel values into queues; a monitor pops and compares on every mem_en_o,
//   pix_valid_o and done_o.
module tb_conv_frame_streamer;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 14;
  localparam int PIX = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          stall_i;
  logic          busy_o;
  logic          done_o;

  conv_frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_frame_streamer #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stall_i     (stall_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural BRAM ----------------
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en_o) bus.mem_data_i <= bram[bus.mem_addr_o];
  end

  // ---------------- conv block model ----------------
  // Running from the arm pulse until hold_val+1 cycles after the last pixel.
  int   hold_val = 5;
  int   pcnt;
  int   hcnt;
  logic run_reg;
  assign bus.conv_running_i = run_reg;
  always @(posedge clk) begin
    if (rst) begin
      run_reg <= 1'b0; pcnt <= 0; hcnt <= -1;
    end else if (bus.conv_ena_o) begin
      run_reg <= 1'b1; pcnt <= 0; hcnt <= -1;
    end else if (bus.pix_valid_o) begin
      pcnt <= pcnt + 1;
      if (pcnt == PIX - 1) hcnt <= hold_val;
    end else if (hcnt > 0) begin
      hcnt <= hcnt - 1;
    end else if (hcnt == 0) begin
      run_reg <= 1'b0; hcnt <= -1;
    end
  end

  // ---------------- stall driver ----------------
  int stall_mode = 0; // 0 none, 1 toggle, 2 random
  initial begin
    stall_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (stall_mode)
        1:       stall_i = ~stall_i;
        2:       stall_i = 1'($urandom_range(0, 1));
        default: stall_i = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard + monitor ----------------
  int exp_pix[$];
  int exp_addr[$];
  bit frame_active = 0;
  int done_cnt = 0;
  int pix_seen = 0;
  int ena_cyc, first_pix_cyc, last_pix_cyc, done_cyc, fall_cyc;
  logic prev_run = 1'b0;

  always @(negedge clk) begin
    if (prev_run === 1'b1 && bus.conv_running_i === 1'b0) fall_cyc = cyc;
    prev_run = bus.conv_running_i;
    if (bus.conv_ena_o) ena_cyc = cyc;
    if (bus.mem_en_o) begin
      if (exp_addr.size() == 0) chk("addr_unexpected", 64'(bus.mem_addr_o), 64'hFFFF_FFFF);
      else chk("mem_addr", 64'(bus.mem_addr_o), 64'(exp_addr.pop_front()));
    end
    if (bus.pix_valid_o) begin
      if (exp_pix.size() == 0) chk("pix_unexpected", 64'(bus.pix_o), 64'hFFFF_FFFF);
      else chk("pix_value", 64'(bus.pix_o), 64'(exp_pix.pop_front()));
      if (pix_seen == 0) first_pix_cyc = cyc;
      last_pix_cyc = cyc;
      pix_seen++;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_expected", 64'(frame_active), 64'd1);
      chk("done_after_pixels", 64'(exp_pix.size()), 64'd0);
      chk("done_after_fall", 64'(done_cyc), 64'(fall_cyc + 1));
      frame_active = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [AW-1:0] base, input bit directed, output int c);
    for (int i = 0; i < PIX; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      bram[a] = directed ? DW'(i + 1) : DW'($urandom);
      exp_pix.push_back(int'(bram[a]));
      exp_addr.push_back(int'(a));
    end
    pix_seen = 0;
    done_cnt = 0;
    frame_active = 1;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; c = cyc;
    @(posedge clk); #1;
    start_i = 1'b0; base_addr_i = AW'($urandom);
  endtask

  task automatic finish_frame(input string name, input int c, input bit directed);
    bit seen = 0;
    int busy_drop = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (done_o) seen = 1;
      else if (!busy_o) busy_drop++;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_busy_held"}, 64'(busy_drop), 64'd0);
    repeat (10) @(negedge clk);
    chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({name, "_pix_left"}, 64'(exp_pix.size()), 64'd0);
    chk({name, "_pix_count"}, 64'(pix_seen), 64'(PIX));
    chk({name, "_idle_busy"}, 64'(busy_o), 64'd0);
    if (directed) begin
      chk({name, "_ena_cycle"}, 64'(ena_cyc), 64'(c + 1));
      chk({name, "_first_pix_cycle"}, 64'(first_pix_cyc), 64'(c + 4));
      chk({name, "_last_pix_cycle"}, 64'(last_pix_cyc), 64'(c + 4 + PIX - 1));
      chk({name, "_done_cycle"}, 64'(done_cyc), 64'(c + 27));
    end
    if (!seen) begin
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
    end
    exp_pix.delete();
    exp_addr.delete();
    frame_active = 0;
    $display("frame %s: start cycle %0d, %0d pixels, done cycle %0d", name, c, pix_seen, done_cyc);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_mem_en"}, 64'(bus.mem_en_o), 64'd0);
    chk({name, "_mem_addr"}, 64'(bus.mem_addr_o), 64'd0);
    chk({name, "_conv_ena"}, 64'(bus.conv_ena_o), 64'd0);
    chk({name, "_pix"}, 64'(bus.pix_o), 64'd0);
    chk({name, "_pix_valid"}, 64'(bus.pix_valid_o), 64'd0);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_done"}, 64'(done_o), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic frame, fixed timing.
    hold_val = 5; stall_mode = 0;
    start_frame(14'd0, 1'b1, c);
    finish_frame("basic", c, 1'b1);

    // Toggling stall.
    stall_mode = 1;
    start_frame(14'd0, 1'b1, c);
    finish_frame("stall_toggle", c, 1'b0);
    stall_mode = 0;

    // Second start mid-frame is ignored.
    start_frame(14'd100, 1'b0, c);
    repeat (7) @(posedge clk);
    #1; start_i = 1'b1; base_addr_i = 14'd5000;
    @(posedge clk); #1; start_i = 1'b0;
    finish_frame("double_start", c, 1'b0);

    // Address wrap at the top of the BRAM.
    start_frame(14'd16380, 1'b0, c);
    finish_frame("addr_wrap", c, 1'b0);

    // Reset mid-stream aborts; in-flight reads vanish, no done.
    start_frame(14'd200, 1'b0, c);
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    exp_pix.delete(); exp_addr.delete(); frame_active = 0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("midreset_no_done", 64'(done_cnt), 64'd0);
    $display("frame midreset: aborted at cycle %0d", c + 10);
    start_frame(14'd300, 1'b0, c);
    finish_frame("after_reset", c, 1'b0);

    // Conv block stays busy long after the last pixel.
    hold_val = 50;
    start_frame(14'd1234, 1'b0, c);
    finish_frame("long_running", c, 1'b0);

    // Randomised frames with random stalls and hold times.
    stall_mode = 2;
    for (int f = 0; f < 5; f++) begin
      hold_val = $urandom_range(0, 12);
      start_frame(AW'($urandom), 1'b0, c);
      finish_frame($sformatf("random%0d", f), c, 1'b0);
    end
    stall_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
